mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (CPU/DMA) memory arbiter with fixed wait-state accesses.
// Optional round-robin arbitration enabled by defining MEM_ARB_RR_EN (default: CPU fixed priority).
module mem_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_CPU_req,
  input  logic        i_CPU_we,
  input  logic        i_CPU_be,
  input  logic [18:0] i_CPU_addr,
  input  logic [15:0] i_CPU_write,
  output logic [15:0] o_CPU_read,
  output logic        o_CPU_ack,
  input  logic        i_DMA_req,
  input  logic        i_DMA_we,
  input  logic        i_DMA_be,
  input  logic [18:0] i_DMA_addr,
  input  logic [15:0] i_DMA_write,
  output logic [15:0] o_DMA_read,
  output logic        o_DMA_ack,
  output logic [18:0] o_MEM_addr,
  output logic [15:0] o_MEM_write,
  output logic        o_MEM_be,
  output logic        o_MEM_we,
  output logic        o_MEM_re,
  input  logic [15:0] i_MEM_read,
  output logic        o_grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_write_q, mem_write_d;
  logic        mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [15:0] cpu_read_q, cpu_read_d;
  logic [15:0] dma_read_q, dma_read_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic        pick_dma;

`ifdef MEM_ARB_RR_EN
  // last_q = 1 means DMA was granted last, so a tie goes to the CPU
  logic last_q, last_d;
  assign pick_dma = i_DMA_req & (~i_CPU_req | ~last_q);
`else
  assign pick_dma = i_DMA_req & ~i_CPU_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_write_d = mem_write_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    cpu_read_d  = cpu_read_q;
    dma_read_d  = dma_read_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_CPU_req || i_DMA_req) begin
          state_d     = ACCESS;
          cnt_d       = 4'(WAIT_STATES);
          grant_d     = pick_dma;
          mem_addr_d  = pick_dma ? i_DMA_addr  : i_CPU_addr;
          mem_write_d = pick_dma ? i_DMA_write : i_CPU_write;
          mem_be_d    = pick_dma ? i_DMA_be    : i_CPU_be;
          mem_we_d    = pick_dma ? i_DMA_we    : i_CPU_we;
          mem_re_d    = pick_dma ? ~i_DMA_we   : ~i_CPU_we;
`ifdef MEM_ARB_RR_EN
          last_d      = pick_dma;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          if (mem_re_q) begin
            if (grant_q) dma_read_d = i_MEM_read;
            else         cpu_read_d = i_MEM_read;
          end
          dma_ack_d   = grant_q;
          cpu_ack_d   = ~grant_q;
          mem_addr_d  = '0;
          mem_write_d = '0;
          mem_be_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_re_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_write_q <= '0;
      mem_be_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cpu_read_q  <= '0;
      dma_read_q  <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cpu_read_q  <= cpu_read_d;
      dma_read_q  <= dma_read_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign o_CPU_read  = cpu_read_q;
  assign o_CPU_ack   = cpu_ack_q;
  assign o_DMA_read  = dma_read_q;
  assign o_DMA_ack   = dma_ack_q;
  assign o_MEM_addr  = mem_addr_q;
  assign o_MEM_write = mem_write_q;
  assign o_MEM_be    = mem_be_q;
  assign o_MEM_we    = mem_we_q;
  assign o_MEM_re    = mem_re_q;
  assign o_grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter.
// Cycle n is the interval after rising edge n; inputs driven and outputs sampled 1ns after the edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req, cpu_we, cpu_be, dma_req, dma_we, dma_be;
  logic [18:0] cpu_addr, dma_addr;
  logic [15:0] cpu_write, dma_write, mem_read;

  logic [15:0] cpu_read, dma_read, mem_write;
  logic        cpu_ack, dma_ack, mem_be, mem_we, mem_re, grant;
  logic [18:0] mem_addr;

  logic [15:0] w0_cpu_read, w0_dma_read, w0_mem_write, w15_cpu_read, w15_dma_read, w15_mem_write;
  logic        w0_cpu_ack, w0_dma_ack, w0_mem_be, w0_mem_we, w0_mem_re, w0_grant;
  logic        w15_cpu_ack, w15_dma_ack, w15_mem_be, w15_mem_we, w15_mem_re, w15_grant;
  logic [18:0] w0_mem_addr, w15_mem_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_STATES(1)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_CPU_req(cpu_req), .i_CPU_we(cpu_we), .i_CPU_be(cpu_be), .i_CPU_addr(cpu_addr),
    .i_CPU_write(cpu_write), .o_CPU_read(cpu_read), .o_CPU_ack(cpu_ack),
    .i_DMA_req(dma_req), .i_DMA_we(dma_we), .i_DMA_be(dma_be), .i_DMA_addr(dma_addr),
    .i_DMA_write(dma_write), .o_DMA_read(dma_read), .o_DMA_ack(dma_ack),
    .o_MEM_addr(mem_addr), .o_MEM_write(mem_write), .o_MEM_be(mem_be), .o_MEM_we(mem_we),
    .o_MEM_re(mem_re), .i_MEM_read(mem_read), .o_grant(grant)
  );

  mem_arbiter #(.WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst(rst),
    .i_CPU_req(cpu_req), .i_CPU_we(cpu_we), .i_CPU_be(cpu_be), .i_CPU_addr(cpu_addr),
    .i_CPU_write(cpu_write), .o_CPU_read(w0_cpu_read), .o_CPU_ack(w0_cpu_ack),
    .i_DMA_req(dma_req), .i_DMA_we(dma_we), .i_DMA_be(dma_be), .i_DMA_addr(dma_addr),
    .i_DMA_write(dma_write), .o_DMA_read(w0_dma_read), .o_DMA_ack(w0_dma_ack),
    .o_MEM_addr(w0_mem_addr), .o_MEM_write(w0_mem_write), .o_MEM_be(w0_mem_be), .o_MEM_we(w0_mem_we),
    .o_MEM_re(w0_mem_re), .i_MEM_read(mem_read), .o_grant(w0_grant)
  );

  mem_arbiter #(.WAIT_STATES(15)) u_ws15 (
    .i_clk(clk), .i_rst(rst),
    .i_CPU_req(cpu_req), .i_CPU_we(cpu_we), .i_CPU_be(cpu_be), .i_CPU_addr(cpu_addr),
    .i_CPU_write(cpu_write), .o_CPU_read(w15_cpu_read), .o_CPU_ack(w15_cpu_ack),
    .i_DMA_req(dma_req), .i_DMA_we(dma_we), .i_DMA_be(dma_be), .i_DMA_addr(dma_addr),
    .i_DMA_write(dma_write), .o_DMA_read(w15_dma_read), .o_DMA_ack(w15_dma_ack),
    .o_MEM_addr(w15_mem_addr), .o_MEM_write(w15_mem_write), .o_MEM_be(w15_mem_be), .o_MEM_we(w15_mem_we),
    .o_MEM_re(w15_mem_re), .i_MEM_read(mem_read), .o_grant(w15_grant)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = '0; cpu_write = '0;
    dma_req = 0; dma_we = 0; dma_be = 0; dma_addr = '0; dma_write = '0;
    mem_read = '0;
  endtask

  task automatic do_reset;
    rst = 1;
    clear_inputs();
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    cpu_req = 1; dma_req = 1; mem_read = 16'hFFFF;
    step();
    step();
    checks += 6;
    if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got cpu=%b dma=%b expected 0 0", cpu_ack, dma_ack); end
    if (cpu_read !== 16'h0) begin errors++; $display("FAIL reset_cpu_read: got %h expected 0000", cpu_read); end
    if (dma_read !== 16'h0) begin errors++; $display("FAIL reset_dma_read: got %h expected 0000", dma_read); end
    if ({mem_we, mem_re, mem_be} !== 3'b000) begin errors++; $display("FAIL reset_mem_strobes: got %b expected 000", {mem_we, mem_re, mem_be}); end
    if (mem_addr !== 19'h0 || mem_write !== 16'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h data=%h expected 0 0", mem_addr, mem_write); end
    if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_cpu_read;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00100; mem_read = 16'hBEEF;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks += 4;
      if (mem_re !== (c <= 2)) begin errors++; $display("FAIL cpu_read_re c%0d: got %b expected %b", c, mem_re, (c <= 2)); end
      if (mem_we !== 1'b0) begin errors++; $display("FAIL cpu_read_we c%0d: got %b expected 0", c, mem_we); end
      if (mem_addr !== ((c <= 2) ? 19'h00100 : 19'h0)) begin errors++; $display("FAIL cpu_read_addr c%0d: got %h", c, mem_addr); end
      if (cpu_ack !== (c == 3)) begin errors++; $display("FAIL cpu_read_ack c%0d: got %b expected %b", c, cpu_ack, (c == 3)); end
      if (c == 3) cpu_req = 0;
    end
    checks++;
    if (cpu_read !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_data: got %h expected beef", cpu_read); end
  endtask

  task automatic test_dma_write;
    // Runs straight after test_cpu_read: CPU read register must keep BEEF
    dma_req = 1; dma_we = 1; dma_be = 1; dma_addr = 19'h00200; dma_write = 16'hA5A5; mem_read = 16'h1111;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks += 5;
      if ({mem_we, mem_be, mem_re} !== ((c <= 2) ? 3'b110 : 3'b000)) begin errors++; $display("FAIL dma_write_strobes c%0d: got we/be/re=%b", c, {mem_we, mem_be, mem_re}); end
      if (mem_write !== ((c <= 2) ? 16'hA5A5 : 16'h0)) begin errors++; $display("FAIL dma_write_data c%0d: got %h", c, mem_write); end
      if (mem_addr !== ((c <= 2) ? 19'h00200 : 19'h0)) begin errors++; $display("FAIL dma_write_addr c%0d: got %h", c, mem_addr); end
      if (dma_ack !== (c == 3) || cpu_ack !== 1'b0) begin errors++; $display("FAIL dma_write_ack c%0d: got dma=%b cpu=%b", c, dma_ack, cpu_ack); end
      if (c <= 3 && grant !== 1'b1) begin errors++; $display("FAIL dma_write_grant c%0d: got %b expected 1", c, grant); end
      if (c == 3) dma_req = 0;
    end
    checks += 2;
    if (dma_read !== 16'h0) begin errors++; $display("FAIL dma_write_read_reg: got %h expected 0000", dma_read); end
    if (cpu_read !== 16'hBEEF) begin errors++; $display("FAIL dma_write_cpu_read: got %h expected beef", cpu_read); end
    clear_inputs();
  endtask

  task automatic test_simultaneous;
    int cyc [3];
    logic own [3];
    int n;
    logic both;
    logic exp_own1;
`ifdef MEM_ARB_RR_EN
    exp_own1 = 1'b1;
`else
    exp_own1 = 1'b0;
`endif
    // Each requester drops its request once acked
    do_reset();
    cpu_req = 1; dma_req = 1; mem_read = 16'h0101;
    cyc[0] = 0; cyc[1] = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (cpu_ack) begin cyc[0] = c; cpu_req = 0; end
      if (dma_ack) begin cyc[1] = c; dma_req = 0; end
    end
    checks += 2;
    if (cyc[0] !== 3) begin errors++; $display("FAIL simul_cpu_ack_cycle: got %0d expected 3", cyc[0]); end
    if (cyc[1] !== 7) begin errors++; $display("FAIL simul_dma_ack_cycle: got %0d expected 7", cyc[1]); end
    // Both held continuously: record the first three completions
    do_reset();
    cpu_req = 1; dma_req = 1;
    n = 0; both = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (cpu_ack && dma_ack) both = 1;
      if ((cpu_ack || dma_ack) && n < 3) begin cyc[n] = c; own[n] = dma_ack; n++; end
    end
    checks += 4;
    if (n !== 3 || cyc[0] !== 3 || cyc[1] !== 7 || cyc[2] !== 11) begin errors++; $display("FAIL b2b_cycles: got n=%0d %0d %0d %0d expected 3 7 11", n, cyc[0], cyc[1], cyc[2]); end
    if (own[0] !== 1'b0 || own[2] !== 1'b0) begin errors++; $display("FAIL b2b_owner_0_2: got %b %b expected 0 0", own[0], own[2]); end
    if (own[1] !== exp_own1) begin errors++; $display("FAIL b2b_owner_1: got %b expected %b", own[1], exp_own1); end
    if (both !== 1'b0) begin errors++; $display("FAIL b2b_single_ack: got both=%b expected 0", both); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_access;
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00300; cpu_write = 16'h1234;
    step();
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_mid_we_before: got %b expected 1", mem_we); end
    rst = 1;
    step();
    rst = 0;
    cpu_req = 0;
    for (int c = 2; c <= 6; c++) begin
      checks += 2;
      if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL rst_mid_strobes c%0d: got we=%b re=%b expected 0 0", c, mem_we, mem_re); end
      if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack c%0d: got %b expected 0", c, cpu_ack); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_drop_req;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00400; mem_read = 16'h1234;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) begin cpu_req = 0; cpu_addr = 19'h7FFFF; cpu_we = 1; end
      checks += 2;
      if (mem_addr !== ((c <= 2) ? 19'h00400 : 19'h0) || mem_re !== (c <= 2)) begin errors++; $display("FAIL drop_req_bus c%0d: got addr=%h re=%b", c, mem_addr, mem_re); end
      if (cpu_ack !== (c == 3)) begin errors++; $display("FAIL drop_req_ack c%0d: got %b expected %b", c, cpu_ack, (c == 3)); end
    end
    checks++;
    if (cpu_read !== 16'h1234) begin errors++; $display("FAIL drop_req_data: got %h expected 1234", cpu_read); end
    clear_inputs();
  endtask

  task automatic test_wait_states;
    int f0;
    int f15;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00010; mem_read = 16'h5A5A;
    f0 = 0; f15 = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (w0_cpu_ack && f0 == 0) f0 = c;
      if (w15_cpu_ack && f15 == 0) f15 = c;
    end
    checks += 3;
    if (f0 !== 2) begin errors++; $display("FAIL ws0_ack_cycle: got %0d expected 2", f0); end
    if (f15 !== 17) begin errors++; $display("FAIL ws15_ack_cycle: got %0d expected 17", f15); end
    if (w15_cpu_read !== 16'h5A5A) begin errors++; $display("FAIL ws15_read_data: got %h expected 5a5a", w15_cpu_read); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_reset_mid_access();
    test_drop_req();
    test_wait_states();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
